// File: rtl/core_ex_wbck.sv
// Writeback arbiter: merges ALU and LSU results onto the single register-file write port,
// with an anti-starvation counter that eventually forces ALU priority over a busy LSU.
module core_ex_wbck #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RFIDX_WIDTH = 5,
    parameter int unsigned STARVE_MAX  = 3
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   alu_wbck_valid,
    output logic                   alu_wbck_ready,
    input  logic [RFIDX_WIDTH-1:0] alu_wbck_idx,
    input  logic [XLEN-1:0]        alu_wbck_dat,

    input  logic                   lsu_wbck_valid,
    output logic                   lsu_wbck_ready,
    input  logic [RFIDX_WIDTH-1:0] lsu_wbck_idx,
    input  logic [XLEN-1:0]        lsu_wbck_dat,

    output logic                   wb_dest_wen,
    output logic [RFIDX_WIDTH-1:0] wb_dest_idx,
    output logic [XLEN-1:0]        wb_dest_dat,
    output logic [3:0]             starve_cnt_o
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic                   starved;
    logic                   alu_fire;
    logic                   lsu_fire;
    logic                   any_fire;
    logic [RFIDX_WIDTH-1:0] sel_idx;
    logic [XLEN-1:0]        sel_dat;
    logic [CNT_W-1:0]       cnt_nxt;

    assign starved = (starve_cnt_o == CNT_MAX);

    // Ready depends only on the other source's valid, so a source can never gate itself.
    always_comb begin
        alu_wbck_ready = 1'b0;
        lsu_wbck_ready = 1'b0;
        if (!rst) begin
            if (starved) begin
                alu_wbck_ready = 1'b1;
                lsu_wbck_ready = !alu_wbck_valid;
            end else begin
                lsu_wbck_ready = 1'b1;
                alu_wbck_ready = !lsu_wbck_valid;
            end
        end
    end

    assign alu_fire = alu_wbck_valid && alu_wbck_ready;
    assign lsu_fire = lsu_wbck_valid && lsu_wbck_ready;
    assign any_fire = alu_fire || lsu_fire;

    // At most one fire per cycle, so a simple priority mux is sufficient.
    always_comb begin
        sel_idx = lsu_wbck_idx;
        sel_dat = lsu_wbck_dat;
        if (alu_fire) begin
            sel_idx = alu_wbck_idx;
            sel_dat = alu_wbck_dat;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        if (alu_wbck_valid && !alu_wbck_ready) begin
            cnt_nxt = starved ? CNT_MAX : CNT_W'(starve_cnt_o + CNT_W'(1));
        end
    end

    // Index/data hold when idle; x0 writes flow through but never raise the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_dest_wen  <= 1'b0;
            wb_dest_idx  <= '0;
            wb_dest_dat  <= '0;
            starve_cnt_o <= '0;
        end else begin
            wb_dest_wen  <= any_fire && (sel_idx != '0);
            starve_cnt_o <= cnt_nxt;
            if (any_fire) begin
                wb_dest_idx <= sel_idx;
                wb_dest_dat <= sel_dat;
            end
        end
    end

endmodule

// File: tb/tb_core_ex_wbck.sv
// Bench for core_ex_wbck: a reference model predicts readies and writebacks, expected
// writebacks are queued at drive time and compared one cycle later.
module tb_core_ex_wbck;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RW    = 5;
    localparam int unsigned SMAX  = 3;

    typedef struct packed {
        logic          wen;
        logic [RW-1:0] idx;
        logic [XLEN-1:0] dat;
    } wb_t;

    logic            clk;
    logic            rst;
    logic            alu_v, alu_r, lsu_v, lsu_r;
    logic [RW-1:0]   alu_idx, lsu_idx;
    logic [XLEN-1:0] alu_dat, lsu_dat;
    logic            wen;
    logic [RW-1:0]   widx;
    logic [XLEN-1:0] wdat;
    logic [3:0]      scnt;

    int checks = 0;
    int errors = 0;

    wb_t             exp_q[$];
    logic [3:0]      m_cnt = '0;
    logic [RW-1:0]   m_idx = '0;
    logic [XLEN-1:0] m_dat = '0;
    logic            last_fa = 1'b0;
    logic            last_fl = 1'b0;

    core_ex_wbck #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .alu_wbck_valid(alu_v), .alu_wbck_ready(alu_r),
        .alu_wbck_idx(alu_idx), .alu_wbck_dat(alu_dat),
        .lsu_wbck_valid(lsu_v), .lsu_wbck_ready(lsu_r),
        .lsu_wbck_idx(lsu_idx), .lsu_wbck_dat(lsu_dat),
        .wb_dest_wen(wen), .wb_dest_idx(widx), .wb_dest_dat(wdat),
        .starve_cnt_o(scnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: check readies/counter, predict and queue the writeback, then compare it.
    task automatic step();
        logic er_alu, er_lsu, fa, fl;
        wb_t  e;
        #2;
        if (rst) begin
            er_alu = 1'b0; er_lsu = 1'b0;
        end else if (m_cnt == 4'(SMAX)) begin
            er_alu = 1'b1; er_lsu = !alu_v;
        end else begin
            er_lsu = 1'b1; er_alu = !lsu_v;
        end
        check("alu_ready", 64'(alu_r), 64'(er_alu));
        check("lsu_ready", 64'(lsu_r), 64'(er_lsu));
        check("starve_cnt", 64'(scnt), 64'(m_cnt));
        fa = alu_v && er_alu;
        fl = lsu_v && er_lsu;
        if (rst) begin
            m_idx = '0; m_dat = '0; m_cnt = '0;
            exp_q.push_back('{wen: 1'b0, idx: '0, dat: '0});
        end else begin
            if (fa) begin
                m_idx = alu_idx; m_dat = alu_dat;
            end else if (fl) begin
                m_idx = lsu_idx; m_dat = lsu_dat;
            end
            exp_q.push_back('{wen: (fa || fl) && (m_idx != '0), idx: m_idx, dat: m_dat});
            if (alu_v && !er_alu)
                m_cnt = (m_cnt == 4'(SMAX)) ? 4'(SMAX) : 4'(m_cnt + 4'd1);
            else
                m_cnt = '0;
        end
        last_fa = fa;
        last_fl = fl;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("wb_wen", 64'(wen), 64'(e.wen));
        check("wb_idx", 64'(widx), 64'(e.idx));
        check("wb_dat", 64'(wdat), 64'(e.dat));
    endtask

    task automatic drive_alu(input logic v, input logic [RW-1:0] i, input logic [XLEN-1:0] d);
        alu_v = v; alu_idx = i; alu_dat = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [RW-1:0] i, input logic [XLEN-1:0] d);
        lsu_v = v; lsu_idx = i; lsu_dat = d;
    endtask

    initial begin
        rst = 1'b1;
        drive_alu(1'b0, '0, '0);
        drive_lsu(1'b0, '0, '0);
        @(posedge clk);
        #1;

        // Reset, with a valid offered that must not transfer
        step();
        drive_alu(1'b1, 5'd9, 32'hDEAD_BEEF);
        step();
        rst = 1'b0;
        drive_alu(1'b0, '0, '0);
        step();

        // Single ALU write
        drive_alu(1'b1, 5'd5, 32'h1234_5678);
        step();
        drive_alu(1'b0, '0, '0);
        step();
        check("single_alu_dat", 64'(wdat), 64'h1234_5678);

        // Collision: LSU first, held ALU next
        drive_lsu(1'b1, 5'd3, 32'hA);
        drive_alu(1'b1, 5'd4, 32'hB);
        step();
        drive_lsu(1'b0, '0, '0);
        step();
        drive_alu(1'b0, '0, '0);
        step();

        // Starvation: busy LSU, held ALU request
        drive_alu(1'b1, 5'd10, 32'hA1A1_A1A1);
        for (int i = 0; i < 6; i++) begin
            drive_lsu(1'b1, 5'd11, XLEN'(32'h100 + i));
            if (last_fa) drive_alu(1'b1, 5'd12, XLEN'(32'h200 + i));
            step();
        end
        drive_alu(1'b0, '0, '0);
        drive_lsu(1'b0, '0, '0);
        step();

        // x0 load write: accepted, no enable
        drive_lsu(1'b1, 5'd0, 32'hFFFF_FFFF);
        step();
        drive_lsu(1'b0, '0, '0);
        step();

        // Reset right after a transfer
        drive_alu(1'b1, 5'd7, 32'hCAFE_F00D);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_alu(1'b0, '0, '0);
        step();
        check("post_rst_dat", 64'(wdat), 64'h0);

        // Streaming: alternating sources, idx 1..8
        for (int i = 1; i <= 8; i++) begin
            if (i % 2 == 1) begin
                drive_alu(1'b1, RW'(i), XLEN'(32'h1000 + i));
                drive_lsu(1'b0, '0, '0);
            end else begin
                drive_alu(1'b0, '0, '0);
                drive_lsu(1'b1, RW'(i), XLEN'(32'h2000 + i));
            end
            step();
        end
        drive_alu(1'b0, '0, '0);
        drive_lsu(1'b0, '0, '0);
        step();

        // Random traffic; a pending unaccepted request keeps its payload stable
        for (int i = 0; i < 300; i++) begin
            if (!alu_v || last_fa) drive_alu(1'($urandom_range(0, 1)), RW'($urandom), XLEN'($urandom));
            if (!lsu_v || last_fl) drive_lsu(1'($urandom_range(0, 1)), RW'($urandom), XLEN'($urandom));
            step();
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
